uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares one `uart_tx` serializer between `NUM_REQ` byte producers on the 25 MHz board clock. It arbitrates round-robin, captures the winner's byte, pulses the serializer's data-valid and holds off further launches until the serializer reports done. It sits between the command/response logic and `uart_tx`, which is instantiated alongside it with the same `CLKS_PER_BIT`.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.

Ports:
- `i_Clock`  in  1: system clock.
- `i_Rst_L`  in  1: asynchronous, active-low reset.
- `i_Req`  in  `NUM_REQ`: bit n high means requester n has a byte pending; level, held until granted.
- `i_Req_Byte`  in  `8*NUM_REQ`: byte of requester n on bits `[8n+7:8n]`; must be stable while `i_Req[n]` is high.
- `i_Lock`  in  `NUM_REQ`: bit n high keeps the grant with requester n for multi-byte packets. Used only with `UART_TX_ARB_LOCK_EN`.
- `o_Grant`  out  `NUM_REQ`: one-hot, one-cycle pulse; the byte of that requester is accepted.
- `o_TX_DV`  out  1: to `uart_tx` `i_TX_DV`; one-cycle pulse.
- `o_TX_Byte`  out  8: to `uart_tx` `i_TX_Byte`; held until the next launch.
- `i_TX_Active`  in  1: from `uart_tx`.
- `i_TX_Done`  in  1: from `uart_tx`; one-cycle pulse after the stop bit.
- `o_Busy`  out  1: high from launch until `i_TX_Done` is seen.

## Operation
- States:
  - `IDLE`: no byte in flight.
  - `BUSY`: a launched byte is in flight.
- `IDLE` → `BUSY`: taken when any bit of `i_Req` is high and `i_TX_Active` is 0. At that edge the arbiter:
  - picks winner w;
  - registers `o_TX_Byte` = byte w;
  - pulses `o_TX_DV` and `o_Grant[w]` for exactly one cycle;
  - sets `o_Busy` = 1;
  - sets the pointer to w.
- `BUSY` → `IDLE`: taken on the edge that samples `i_TX_Done` = 1. `o_Busy` clears at that edge. `i_Req` is ignored while in `BUSY`.
- Round-robin: the search starts at pointer+1 and wraps modulo `NUM_REQ`, so the last winner has lowest priority. The pointer resets to `NUM_REQ-1`, which makes requester 0 first after reset.
- Requesters deassert `i_Req`, or present their next byte, by the edge after their `o_Grant`. A still-high `i_Req` is treated as a new byte at the next arbitration.
- `i_TX_Active` high in `IDLE`, for example after a reset mid-frame, blocks any launch until it falls. Frames are never overlapped.
- `i_TX_Done` seen in `IDLE` is ignored.
- Reset values: state `IDLE`, `o_Grant` = 0, `o_TX_DV` = 0, `o_TX_Byte` = 8'h00, `o_Busy` = 0, pointer = `NUM_REQ-1`, lock owner cleared. Reset mid-`BUSY` abandons the in-flight bookkeeping immediately.

## Timing
- Grant/launch latency: `i_Req` sampled high in `IDLE` with `i_TX_Active` = 0 at edge N gives `o_Grant` and `o_TX_DV` high during cycle N..N+1.
- Back-to-back: `i_TX_Done` sampled at edge K moves to `IDLE`. The next launch is at edge K+1 at the earliest, so there is 1 idle cycle between `i_TX_Done` and the next `o_TX_DV`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `UART_TX_ARB_LOCK_EN`.
- Defined:
  - If `i_Lock[w]` is high when `i_TX_Done` is sampled, the arbiter enters `IDLE` with requester w as lock owner.
  - While locked, only w is eligible, and the pointer does not advance past w.
  - If w has no request, the arbiter waits.
  - The lock releases when `i_Lock[w]` is low in `IDLE` or at the next `i_TX_Done`; normal round-robin then resumes from w+1.
- Undefined: `i_Lock` is ignored, no lock register is synthesized, and the arbiter is pure round-robin.

## Structure
- Package `uart_pkg`:
  - state enum `uart_tx_arb_state_t` (`IDLE`, `BUSY`);
  - constant `UART_BYTE_W` = 8.
- Sub-module `rr_pick`: combinational round-robin picker. It takes request vector and pointer, and returns one-hot grant plus index. It is reused by later arbiters.

## Test plan
Benches use `uart_tx` with `CLKS_PER_BIT` = 217 and a 40 ns clock.
- Single request: `i_Req`=4'b0001, byte0=8'h37 → `o_Grant`=0001 and `o_TX_DV` pulse on the same cycle; serial line carries 0x37 LSB-first; `o_Busy` falls one cycle after `i_TX_Done`.
- Fairness: all four requesting continuously with bytes 8'hA0..8'hA3 → serial order A0, A1, A2, A3, A0; no `o_TX_DV` while `o_Busy`=1.
- Back-to-back gap: two requesters → exactly 1 cycle between the first `i_TX_Done` and the second `o_TX_DV`.
- Reset mid-frame: `i_Rst_L` low 3 cycles during the 4th data bit with `i_Req`=0010 pending → all outputs 0 during reset; the next `o_TX_DV` occurs only after `i_TX_Active` falls.
- Lock (`UART_TX_ARB_LOCK_EN`): requester 2 holds `i_Lock` for 3 bytes 8'h11, 8'h22, 8'h33 while requester 0 requests 8'h55 → serial 11, 22, 33, 55. Without the macro: 11, 55, 22, 33 (requester 2 re-requests after each grant).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } uart_tx_arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; searches from i_Ptr+1 upward, wrapping
// modulo N, so the requester at i_Ptr has the lowest priority.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     i_Req,
    input  logic [PTR_W-1:0] i_Ptr,
    output logic [N-1:0]     o_Grant,
    output logic [PTR_W-1:0] o_Idx,
    output logic             o_Valid
);

    int               cand;
    logic [PTR_W-1:0] cand_idx;

    // Walk from the farthest offset down so the nearest requester overwrites last.
    always_comb begin
        o_Grant  = '0;
        o_Idx    = '0;
        o_Valid  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int off = N; off >= 1; off--) begin
            cand     = (int'(i_Ptr) + off) % N;
            cand_idx = PTR_W'(cand);
            if (i_Req[cand_idx]) begin
                o_Grant           = '0;
                o_Grant[cand_idx] = 1'b1;
                o_Idx             = cand_idx;
                o_Valid           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// Define UART_TX_ARB_LOCK_EN to let a requester keep the grant across a multi-byte packet.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                           i_Clock,
    input  logic                           i_Rst_L,
    input  logic [NUM_REQ-1:0]             i_Req,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] i_Req_Byte,
    input  logic [NUM_REQ-1:0]             i_Lock,
    output logic [NUM_REQ-1:0]             o_Grant,
    output logic                           o_TX_DV,
    output logic [UART_BYTE_W-1:0]         o_TX_Byte,
    input  logic                           i_TX_Active,
    input  logic                           i_TX_Done,
    output logic                           o_Busy,
    output logic                           o_Dbg_State
);

    localparam int PTR_W = $clog2(NUM_REQ);

    uart_tx_arb_state_t     state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic                   tx_dv_q, tx_dv_d;
    logic [UART_BYTE_W-1:0] tx_byte_q, tx_byte_d;
    logic                   busy_q, busy_d;

    logic [NUM_REQ-1:0]     elig_req;
    logic [NUM_REQ-1:0]     pick_grant;
    logic [PTR_W-1:0]       pick_idx;
    logic                   pick_vld;
    logic [UART_BYTE_W-1:0] win_byte;

`ifdef UART_TX_ARB_LOCK_EN
    logic             lock_vld_q, lock_vld_d;
    logic [PTR_W-1:0] lock_idx_q, lock_idx_d;

    // A held lock narrows eligibility to the owner; everyone else waits.
    always_comb begin
        elig_req = i_Req;
        if (lock_vld_q && i_Lock[lock_idx_q]) begin
            elig_req             = '0;
            elig_req[lock_idx_q] = i_Req[lock_idx_q];
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^i_Lock;
    assign elig_req    = i_Req;
`endif

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .i_Req   (elig_req),
        .i_Ptr   (ptr_q),
        .o_Grant (pick_grant),
        .o_Idx   (pick_idx),
        .o_Valid (pick_vld)
    );

    always_comb begin
        win_byte = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (pick_grant[n]) win_byte = i_Req_Byte[n*UART_BYTE_W +: UART_BYTE_W];
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = '0;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        busy_d    = busy_q;
`ifdef UART_TX_ARB_LOCK_EN
        lock_vld_d = lock_vld_q;
        lock_idx_d = lock_idx_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef UART_TX_ARB_LOCK_EN
                if (lock_vld_q && !i_Lock[lock_idx_q]) lock_vld_d = 1'b0;
`endif
                // An active serializer (e.g. after reset mid-frame) blocks any launch.
                if (pick_vld && !i_TX_Active) begin
                    state_d   = BUSY;
                    ptr_d     = pick_idx;
                    grant_d   = pick_grant;
                    tx_dv_d   = 1'b1;
                    tx_byte_d = win_byte;
                    busy_d    = 1'b1;
                end
            end
            BUSY: begin
                if (i_TX_Done) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
                    lock_vld_d = i_Lock[ptr_q];
                    lock_idx_d = ptr_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= IDLE;
            ptr_q     <= PTR_W'(NUM_REQ - 1);
            grant_q   <= '0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
            busy_q    <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            busy_q    <= busy_d;
`ifdef UART_TX_ARB_LOCK_EN
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
`endif
        end
    end

    assign o_Grant     = grant_q;
    assign o_TX_DV     = tx_dv_q;
    assign o_TX_Byte   = tx_byte_q;
    assign o_Busy      = busy_q;
    assign o_Dbg_State = state_q;

endmodule
